// File: rtl/odd_pipe_pkg.sv
// Shared types and default configuration for the odd/even execution pipe result stage.
package odd_pipe_pkg;

    localparam int unsigned STAGE_DATA_W    = 128;
    localparam int unsigned STAGE_ADDR_W    = 7;
    localparam int unsigned STAGE_DEPTH     = 7;
    localparam int unsigned STAGE_NUM_UNITS = 3;
    localparam int unsigned STAGE_NUM_RD    = 3;

    localparam int unsigned DEFAULT_UNIT_SLOT [STAGE_NUM_UNITS] = '{5, 3, 0};

    typedef struct packed {
        logic                    valid;
        logic [STAGE_ADDR_W-1:0] addr;
        logic [STAGE_DATA_W-1:0] data;
    } stage_entry_t;

    typedef enum logic [1:0] {
        PERM = 2'd0,
        LS   = 2'd1,
        BR   = 2'd2
    } unit_sel_t;

endpackage

// File: rtl/result_stage_pipe_if.sv
// Bundles unit injection, flush, forwarding and staging signals of result_stage_pipe.
// Perf counter outputs exist only when RESULT_STAGE_PERF_EN is defined.
interface result_stage_pipe_if #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DEPTH     = 7,
    parameter int unsigned NUM_UNITS = 3,
    parameter int unsigned NUM_RD    = 3
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 2);

    logic [NUM_UNITS-1:0]             i_unit_valid;
    logic [NUM_UNITS-1:0][DATA_W-1:0] i_unit_data;
    logic [NUM_UNITS-1:0][ADDR_W-1:0] i_unit_addr;
    logic                             i_flush;
    logic [DEPTH-1:0]                 i_flush_mask;
    logic [NUM_RD-1:0][ADDR_W-1:0]    i_rd_addr;
    logic [NUM_RD-1:0]                o_rd_hit;
    logic [NUM_RD-1:0][DATA_W-1:0]    o_rd_data;
    logic [DEPTH-1:0][DATA_W-1:0]     o_stg_data;
    logic [DEPTH-1:0][ADDR_W-1:0]     o_stg_addr;
    logic [DEPTH-1:0]                 o_stg_valid;
    logic [DATA_W-1:0]                o_wb_data;
    logic [ADDR_W-1:0]                o_wb_addr;
    logic                             o_wb_valid;
    logic [OCC_W-1:0]                 o_occupancy;
    logic                             o_collision;
`ifdef RESULT_STAGE_PERF_EN
    logic [15:0]                      o_collision_cnt;
    logic [15:0]                      o_flush_cnt;
`endif

    modport master (
        output i_unit_valid, i_unit_data, i_unit_addr, i_flush, i_flush_mask, i_rd_addr,
`ifdef RESULT_STAGE_PERF_EN
        input  o_collision_cnt, o_flush_cnt,
`endif
        input  o_rd_hit, o_rd_data, o_stg_data, o_stg_addr, o_stg_valid,
        input  o_wb_data, o_wb_addr, o_wb_valid, o_occupancy, o_collision
    );

    modport slave (
        input  i_unit_valid, i_unit_data, i_unit_addr, i_flush, i_flush_mask, i_rd_addr,
`ifdef RESULT_STAGE_PERF_EN
        output o_collision_cnt, o_flush_cnt,
`endif
        output o_rd_hit, o_rd_data, o_stg_data, o_stg_addr, o_stg_valid,
        output o_wb_data, o_wb_addr, o_wb_valid, o_occupancy, o_collision
    );

endinterface

// File: rtl/result_stage_pipe_fwd_lookup.sv
// One forwarding query port: priority match over the staged entries, lowest index wins.
module result_stage_pipe_fwd_lookup #(
    parameter int unsigned NUM_ENT = 8,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 128
) (
    input  logic [NUM_ENT-1:0]             i_valid,
    input  logic [NUM_ENT-1:0][ADDR_W-1:0] i_addr,
    input  logic [NUM_ENT-1:0][DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0]              i_rd_addr,
    output logic                           o_hit,
    output logic [DATA_W-1:0]              o_data
);

    // Scan from oldest to youngest so the youngest match is the last assignment.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_addr[i] == i_rd_addr)) begin
                o_hit  = 1'b1;
                o_data = i_data[i];
            end
        end
    end

endmodule

// File: rtl/result_stage_pipe.sv
// Result staging shift register with per-slot injection, flush, collision flag and forwarding.
// Optional perf counters (collision_cnt, flush_cnt) under RESULT_STAGE_PERF_EN.
module result_stage_pipe
    import odd_pipe_pkg::*;
#(
    parameter int unsigned DATA_W                = STAGE_DATA_W,
    parameter int unsigned ADDR_W                = STAGE_ADDR_W,
    parameter int unsigned DEPTH                 = STAGE_DEPTH,
    parameter int unsigned NUM_UNITS             = STAGE_NUM_UNITS,
    parameter int unsigned UNIT_SLOT [NUM_UNITS] = DEFAULT_UNIT_SLOT,
    parameter int unsigned NUM_RD                = STAGE_NUM_RD
) (
    input  logic              clk,
    input  logic              reset,
    result_stage_pipe_if.slave bus
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 2);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_slot_chk
        if (UNIT_SLOT[u] >= DEPTH) begin : g_range
            $error("result_stage_pipe: UNIT_SLOT entry out of range");
        end
        for (genvar v = u + 1; v < NUM_UNITS; v++) begin : g_dup
            if (UNIT_SLOT[u] == UNIT_SLOT[v]) begin : g_eq
                $error("result_stage_pipe: duplicate UNIT_SLOT entries");
            end
        end
    end

    entry_t             r_stg  [DEPTH];
    entry_t             r_wb;
    logic               r_collision;
    logic [OCC_W-1:0]   r_occ;

    entry_t             w_prev [DEPTH];
    entry_t             w_pre  [DEPTH];
    entry_t             w_nxt  [DEPTH];
    logic [DEPTH-1:0]   w_kill;
    logic [DEPTH-1:0]   w_col_stg;
    logic               w_col;
    logic [OCC_W-1:0]   w_occ;

    for (genvar k = 0; k < DEPTH; k++) begin : g_prev
        if (k == 0) begin : g_head
            assign w_prev[k] = '0;
        end else begin : g_shift
            assign w_prev[k] = r_stg[k-1];
        end
    end

    always_comb begin
        w_col_stg = '0;
        w_kill    = '0;
        w_occ     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_pre[k] = w_prev[k];
            for (int u = 0; u < NUM_UNITS; u++) begin
                if ((UNIT_SLOT[u] == unsigned'(k)) && bus.i_unit_valid[u]) begin
                    w_pre[k].valid = 1'b1;
                    w_pre[k].addr  = bus.i_unit_addr[u];
                    w_pre[k].data  = bus.i_unit_data[u];
                    w_col_stg[k]   = w_prev[k].valid;
                end
            end
            // Flush wins over injection; a collision on the same stage is still flagged.
            w_kill[k] = bus.i_flush & bus.i_flush_mask[k];
            w_nxt[k]  = w_kill[k] ? '0 : w_pre[k];
            w_occ     = w_occ + OCC_W'(w_nxt[k].valid);
        end
        w_occ = w_occ + OCC_W'(r_stg[DEPTH-1].valid);
        w_col = |w_col_stg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stg       <= '{default: '0};
            r_wb        <= '0;
            r_collision <= 1'b0;
            r_occ       <= '0;
        end else begin
            r_stg       <= w_nxt;
            r_wb        <= r_stg[DEPTH-1];
            r_collision <= w_col;
            r_occ       <= w_occ;
        end
    end

    // Forwarding sees stages 0..DEPTH-1 then writeback at index DEPTH.
    logic [DEPTH:0]             w_fwd_valid;
    logic [DEPTH:0][ADDR_W-1:0] w_fwd_addr;
    logic [DEPTH:0][DATA_W-1:0] w_fwd_data;

    for (genvar k = 0; k < DEPTH; k++) begin : g_out
        assign bus.o_stg_valid[k] = r_stg[k].valid;
        assign bus.o_stg_addr[k]  = r_stg[k].addr;
        assign bus.o_stg_data[k]  = r_stg[k].data;
        assign w_fwd_valid[k]     = r_stg[k].valid;
        assign w_fwd_addr[k]      = r_stg[k].addr;
        assign w_fwd_data[k]      = r_stg[k].data;
    end
    assign w_fwd_valid[DEPTH] = r_wb.valid;
    assign w_fwd_addr[DEPTH]  = r_wb.addr;
    assign w_fwd_data[DEPTH]  = r_wb.data;

    logic [NUM_RD-1:0]             w_rd_hit;
    logic [NUM_RD-1:0][DATA_W-1:0] w_rd_data;

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        result_stage_pipe_fwd_lookup #(
            .NUM_ENT (DEPTH + 1),
            .ADDR_W  (ADDR_W),
            .DATA_W  (DATA_W)
        ) u_fwd_lookup (
            .i_valid   (w_fwd_valid),
            .i_addr    (w_fwd_addr),
            .i_data    (w_fwd_data),
            .i_rd_addr (bus.i_rd_addr[r]),
            .o_hit     (w_rd_hit[r]),
            .o_data    (w_rd_data[r])
        );
    end

    assign bus.o_rd_hit    = w_rd_hit;
    assign bus.o_rd_data   = w_rd_data;
    assign bus.o_wb_valid  = r_wb.valid;
    assign bus.o_wb_addr   = r_wb.addr;
    assign bus.o_wb_data   = r_wb.data;
    assign bus.o_occupancy = r_occ;
    assign bus.o_collision = r_collision;

`ifdef RESULT_STAGE_PERF_EN
    logic [15:0]                  r_collision_cnt;
    logic [15:0]                  r_flush_cnt;
    logic [$clog2(DEPTH+1)-1:0]   w_kill_cnt;
    logic [16:0]                  w_flush_sum;

    // Kills count entries that would otherwise have been valid, injected ones included.
    always_comb begin
        w_kill_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_kill_cnt = w_kill_cnt + ($clog2(DEPTH+1))'(w_pre[k].valid & w_kill[k]);
        end
        w_flush_sum = {1'b0, r_flush_cnt} + 17'(w_kill_cnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_collision_cnt <= '0;
            r_flush_cnt     <= '0;
        end else begin
            if (w_col && (r_collision_cnt != 16'hFFFF)) begin
                r_collision_cnt <= r_collision_cnt + 16'd1;
            end
            r_flush_cnt <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
        end
    end

    assign bus.o_collision_cnt = r_collision_cnt;
    assign bus.o_flush_cnt     = r_flush_cnt;
`endif

endmodule

// File: tb/tb_result_stage_pipe.sv
// Directed self-checking bench for result_stage_pipe with default parameters.
module tb_result_stage_pipe;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    result_stage_pipe_if bus ();

    result_stage_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.i_unit_valid = '0;
        bus.i_unit_data  = '0;
        bus.i_unit_addr  = '0;
        bus.i_flush      = 1'b0;
        bus.i_flush_mask = '0;
    endtask

    // Unit 0 -> slot 5, unit 1 -> slot 3, unit 2 -> slot 0.
    task automatic inject(input int u, input logic [6:0] addr, input logic [127:0] data);
        bus.i_unit_valid[u] = 1'b1;
        bus.i_unit_addr[u]  = addr;
        bus.i_unit_data[u]  = data;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        clear_in();
        bus.i_rd_addr = '0;
        step();
        step();
        check("rst_stg_valid", bus.o_stg_valid, 7'b0);
        check("rst_wb_valid", bus.o_wb_valid, 1'b0);
        check("rst_occ", bus.o_occupancy, 4'd0);
        check("rst_collision", bus.o_collision, 1'b0);
        check("rst_rd_hit", bus.o_rd_hit, 3'b000);
        reset = 1'b0;
        step();

        // Single injection at slot 5 travels to writeback in 2 more cycles.
        inject(0, 7'd10, 128'hAAAA);
        bus.i_rd_addr[0] = 7'd10;
        step();
        clear_in();
        check("a_stg_valid1", bus.o_stg_valid, 7'b0100000);
        check("a_stg_addr5", bus.o_stg_addr[5], 7'd10);
        check("a_occ1", bus.o_occupancy, 4'd1);
        check("a_fwd_hit", bus.o_rd_hit[0], 1'b1);
        check("a_fwd_data", bus.o_rd_data[0], 128'hAAAA);
        step();
        check("a_stg_valid2", bus.o_stg_valid, 7'b1000000);
        step();
        check("a_wb_valid", bus.o_wb_valid, 1'b1);
        check("a_wb_addr", bus.o_wb_addr, 7'd10);
        check("a_wb_data", bus.o_wb_data, 128'hAAAA);
        check("a_stg_empty", bus.o_stg_valid, 7'b0);
        check("a_occ_wb", bus.o_occupancy, 4'd1);
        step();
        check("a_wb_gone", bus.o_wb_valid, 1'b0);
        check("a_occ0", bus.o_occupancy, 4'd0);

        // Several entries in flight, address 0 forwarding, then mid-operation reset.
        inject(2, 7'd0, 128'h5);
        bus.i_rd_addr[2] = 7'd0;
        step();
        clear_in();
        check("e_fwd0_hit", bus.o_rd_hit[2], 1'b1);
        check("e_fwd0_data", bus.o_rd_data[2], 128'h5);
        inject(0, 7'd1, 128'h11);
        inject(1, 7'd2, 128'h22);
        inject(2, 7'd3, 128'h33);
        step();
        clear_in();
        check("e_stg_valid", bus.o_stg_valid, 7'b0101011);
        check("e_occ4", bus.o_occupancy, 4'd4);
        check("e_no_col", bus.o_collision, 1'b0);
        check("e_fwd0_data2", bus.o_rd_data[2], 128'h5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("e_rst_valid", bus.o_stg_valid, 7'b0);
        check("e_rst_wb", bus.o_wb_valid, 1'b0);
        check("e_rst_occ", bus.o_occupancy, 4'd0);
        check("e_rst_hit", bus.o_rd_hit, 3'b000);

        // Slot-0 entry reaches stage 2, then a slot-3 injection overwrites it.
        inject(2, 7'd4, 128'h44);
        step();
        clear_in();
        step();
        step();
        check("b_stg2", bus.o_stg_addr[2], 7'd4);
        check("b_no_col", bus.o_collision, 1'b0);
        inject(1, 7'd9, 128'h99);
        step();
        clear_in();
        check("b_col", bus.o_collision, 1'b1);
        check("b_stg_valid", bus.o_stg_valid, 7'b0001000);
        check("b_stg3_addr", bus.o_stg_addr[3], 7'd9);
        check("b_occ", bus.o_occupancy, 4'd1);
        step();
        check("b_col_pulse", bus.o_collision, 1'b0);
        step();
        step();
        step();
        check("b_wb_valid", bus.o_wb_valid, 1'b1);
        check("b_wb_addr", bus.o_wb_addr, 7'd9);
        check("b_wb_data", bus.o_wb_data, 128'h99);
        step();
        check("b_wb_only_one", bus.o_wb_valid, 1'b0);

        // Fill all stages from slot 0, then flush stages 0-2.
        for (int i = 0; i < 7; i++) begin
            inject(2, 7'(20 + i), 128'(256 + i));
            step();
        end
        clear_in();
        check("c_full", bus.o_stg_valid, 7'h7F);
        check("c_occ7", bus.o_occupancy, 4'd7);
        bus.i_flush      = 1'b1;
        bus.i_flush_mask = 7'b0000111;
        step();
        clear_in();
        check("c_flush_valid", bus.o_stg_valid, 7'b1111000);
        check("c_stg3_addr", bus.o_stg_addr[3], 7'd24);
        check("c_stg3_data", bus.o_stg_data[3], 128'h104);
        check("c_stg6_addr", bus.o_stg_addr[6], 7'd21);
        check("c_stg1_addr0", bus.o_stg_addr[1], 7'd0);
        check("c_stg1_data0", bus.o_stg_data[1], 128'h0);
        check("c_wb_addr", bus.o_wb_addr, 7'd20);
        check("c_occ5", bus.o_occupancy, 4'd5);
`ifdef RESULT_STAGE_PERF_EN
        check("c_flush_cnt", bus.o_flush_cnt, 16'd2);
`endif
        inject(2, 7'd30, 128'h30);
        bus.i_flush      = 1'b1;
        bus.i_flush_mask = 7'b0000001;
        step();
        clear_in();
        check("c_inj_flushed", bus.o_stg_valid, 7'b1110000);
        check("c_inj_addr0", bus.o_stg_addr[0], 7'd0);
        check("c_occ4", bus.o_occupancy, 4'd4);
        for (int i = 0; i < 8; i++) step();
        check("c_drained", bus.o_occupancy, 4'd0);

        // Two entries for address 12; the younger one must be forwarded.
        bus.i_rd_addr[0] = 7'd12;
        bus.i_rd_addr[1] = 7'd13;
        inject(2, 7'd12, 128'h2);
        step();
        clear_in();
        step();
        step();
        inject(2, 7'd12, 128'h1);
        step();
        clear_in();
        step();
        check("d_stg_valid", bus.o_stg_valid, 7'b0010010);
        check("d_hit12", bus.o_rd_hit[0], 1'b1);
        check("d_data12", bus.o_rd_data[0], 128'h1);
        check("d_hit13", bus.o_rd_hit[1], 1'b0);
        check("d_data13", bus.o_rd_data[1], 128'h0);
        step();
        step();
        step();
        check("d_wb_old", bus.o_wb_data, 128'h2);
        check("d_stg_over_wb", bus.o_rd_data[0], 128'h1);
        step();
        step();
        step();
        check("d_wb_only_hit", bus.o_rd_hit[0], 1'b1);
        check("d_wb_only_data", bus.o_rd_data[0], 128'h1);
        check("d_wb_only_occ", bus.o_occupancy, 4'd1);
        step();
        step();

        // Back-to-back collisions at slot 3, the second on a flushed stage.
        inject(2, 7'd41, 128'h41);
        step();
        inject(2, 7'd42, 128'h42);
        step();
        inject(2, 7'd43, 128'h43);
        step();
        inject(2, 7'd44, 128'h44);
        inject(1, 7'd50, 128'h50);
        step();
        clear_in();
        check("f_col1", bus.o_collision, 1'b1);
        check("f_stg3", bus.o_stg_addr[3], 7'd50);
        inject(1, 7'd51, 128'h51);
        bus.i_flush      = 1'b1;
        bus.i_flush_mask = 7'b0001000;
        step();
        clear_in();
        check("f_col_flushed", bus.o_collision, 1'b1);
        check("f_stg_valid", bus.o_stg_valid, 7'b0010110);
        check("f_stg3_empty", bus.o_stg_addr[3], 7'd0);
        step();
        check("f_col_clear", bus.o_collision, 1'b0);
`ifdef RESULT_STAGE_PERF_EN
        check("f_collision_cnt", bus.o_collision_cnt, 16'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
